reset_sequencer: RTL and testbench

- Sits directly downstream of the board clock unit.
- Runs on the 40 MHz system clock and consumes the DCM lock status and the IODELAYCTRL ready flag, both asynchronous.
- Produces an ordered, glitch-free reset release: IDELAYCTRL reset pulse, then IO-stage reset, then core reset.
- Monitors lock loss and re-runs the sequence when the DCM drops lock.

---
 rtl/reset_sequencer_if.sv | 22 ++
 rtl/reset_sequencer.sv | 78 +++++++
 tb/tb_reset_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: async lock/ready status in, ordered resets and status out
interface reset_sequencer_if #(
  parameter int LOSS_CNT_W = 8
);
  logic clk_locked;
  logic idc_rdy;
  logic idc_rst;
  logic rst_io;
  logic rst_core;
  logic sys_ready;
  logic timeout_flag;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;
  logic [2:0] state_dbg;
  modport master (
    input  clk_locked, idc_rdy,
    output idc_rst, rst_io, rst_core, sys_ready, timeout_flag, lock_loss_cnt, state_dbg
  );
  modport slave (
    output clk_locked, idc_rdy,
    input  idc_rst, rst_io, rst_core, sys_ready, timeout_flag, lock_loss_cnt, state_dbg
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered IDELAYCTRL/IO/core reset release with lock and ready supervision
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int IDC_RST_CYCLES = 16,
  parameter int RDY_TIMEOUT = 4096,
  parameter int IO_TO_CORE_GAP = 8,
  parameter int LOSS_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  reset_sequencer_if.master bus
);
  localparam int MAX_A = LOCK_STABLE_CYCLES > IDC_RST_CYCLES ? LOCK_STABLE_CYCLES : IDC_RST_CYCLES;
  localparam int MAX_B = RDY_TIMEOUT > IO_TO_CORE_GAP ? RDY_TIMEOUT : IO_TO_CORE_GAP;
  localparam int CNT_W = $clog2(MAX_A > MAX_B ? MAX_A : MAX_B) + 1;
  localparam logic [CNT_W-1:0] LOCK_END = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDC_END = CNT_W'(IDC_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RDY_END = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(IO_TO_CORE_GAP - 1);
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    IDC_RST   = 3'd1,
    WAIT_RDY  = 3'd2,
    REL_IO    = 3'd3,
    REL_CORE  = 3'd4,
    RUN       = 3'd5
  } state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic lock_m, lock_s, rdy_m, rdy_s;
  logic timeout_hit, loss_hit;
  always_comb begin
    nxt = state;
    case (state)
      WAIT_LOCK: nxt = lock_s && cnt == LOCK_END ? IDC_RST : WAIT_LOCK;
      IDC_RST:   nxt = cnt == IDC_END ? WAIT_RDY : IDC_RST;
      WAIT_RDY:  nxt = rdy_s ? REL_IO : cnt == RDY_END ? IDC_RST : WAIT_RDY;
      REL_IO:    nxt = cnt == GAP_END ? REL_CORE : REL_IO;
      REL_CORE:  nxt = RUN;
      RUN:       nxt = RUN;
      default:   nxt = WAIT_LOCK;
    endcase
    if (state >= REL_IO && !rdy_s) nxt = IDC_RST;
    if (state != WAIT_LOCK && !lock_s) nxt = WAIT_LOCK;
  end
  assign timeout_hit = lock_s && state == WAIT_RDY && !rdy_s && cnt == RDY_END;
  assign loss_hit = state == RUN && !lock_s;
  assign bus.state_dbg = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
      state <= WAIT_LOCK;
      cnt <= '0;
      bus.idc_rst <= 1'b1;
      bus.rst_io <= 1'b1;
      bus.rst_core <= 1'b1;
      bus.sys_ready <= 1'b0;
      bus.timeout_flag <= 1'b0;
      bus.lock_loss_cnt <= '0;
    end else begin
      lock_m <= bus.clk_locked;
      lock_s <= lock_m;
      rdy_m <= bus.idc_rdy;
      rdy_s <= rdy_m;
      state <= nxt;
      cnt <= (nxt != state || (state == WAIT_LOCK && !lock_s) || state == RUN) ? '0 : cnt + CNT_W'(1);
      bus.idc_rst <= nxt == WAIT_LOCK || nxt == IDC_RST;
      bus.rst_io <= nxt < REL_IO;
      bus.rst_core <= nxt < REL_CORE;
      bus.sys_ready <= nxt == RUN;
      bus.timeout_flag <= bus.timeout_flag | timeout_hit;
      bus.lock_loss_cnt <= bus.lock_loss_cnt + LOSS_CNT_W'(loss_hit && !(&bus.lock_loss_cnt));
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table vectors, corner sequences and a phase/dwell reference model
module tb_reset_sequencer;
  localparam int LSC = 8;
  localparam int IDC = 4;
  localparam int RTO = 16;
  localparam int GAP = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lk = 1'b0;
  logic rd = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  reset_sequencer_if #(.LOSS_CNT_W(8)) bus ();
  reset_sequencer_if #(.LOSS_CNT_W(2)) bus2 ();
  assign bus.clk_locked = lk;
  assign bus.idc_rdy = rd;
  assign bus2.clk_locked = lk;
  assign bus2.idc_rdy = rd;
  reset_sequencer #(.LOCK_STABLE_CYCLES(LSC), .IDC_RST_CYCLES(IDC), .RDY_TIMEOUT(RTO),
                    .IO_TO_CORE_GAP(GAP), .LOSS_CNT_W(8))
    dut (.clk(clk), .rst(rst), .bus(bus.master));
  reset_sequencer #(.LOCK_STABLE_CYCLES(LSC), .IDC_RST_CYCLES(IDC), .RDY_TIMEOUT(RTO),
                    .IO_TO_CORE_GAP(GAP), .LOSS_CNT_W(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.master));
  wire [17:0] ob = {bus.state_dbg, bus.idc_rst, bus.rst_io, bus.rst_core, bus.sys_ready,
                    bus.timeout_flag, bus.lock_loss_cnt, bus2.lock_loss_cnt};
  // reference: synchroniser as 2-deep queues, phase + dwell time, global lock run length
  bit lq[$];
  bit rq[$];
  int m_ph = 0;
  int m_t = 0;
  int m_run = 0;
  int m_loss = 0;
  bit m_tf = 1'b0;
  function automatic logic [2:0] rmap(int p);
    return p < 2 ? 3'b111 : p == 2 ? 3'b011 : p == 3 ? 3'b001 : 3'b000;
  endfunction
  function automatic logic [17:0] mexp();
    int l8;
    int l2;
    l8 = m_loss > 255 ? 255 : m_loss;
    l2 = m_loss > 3 ? 3 : m_loss;
    return {3'(m_ph), rmap(m_ph), m_ph == 5, m_tf, 8'(l8), 2'(l2)};
  endfunction
  task automatic model_step();
    bit ls;
    bit rs;
    int np;
    if (rst) begin
      m_ph = 0; m_t = 0; m_run = 0; m_loss = 0; m_tf = 1'b0;
      lq = '{1'b0, 1'b0};
      rq = '{1'b0, 1'b0};
      return;
    end
    ls = lq.pop_front();
    rs = rq.pop_front();
    lq.push_back(lk);
    rq.push_back(rd);
    m_run = ls ? m_run + 1 : 0;
    np = m_ph;
    if (m_ph != 0 && !ls) begin
      np = 0;
      if (m_ph == 5) m_loss++;
    end else if (m_ph >= 3 && !rs) np = 1;
    else if (m_ph == 0 && m_run >= LSC) np = 1;
    else if (m_ph == 1 && m_t + 1 == IDC) np = 2;
    else if (m_ph == 2 && rs) np = 3;
    else if (m_ph == 2 && m_t + 1 == RTO) begin
      np = 1;
      m_tf = 1'b1;
    end else if (m_ph == 3 && m_t + 1 == GAP) np = 4;
    else if (m_ph == 4) np = 5;
    m_t = np != m_ph ? 0 : m_t + 1;
    m_ph = np;
  endtask
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model", 32'(ob), 32'(mexp()));
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic wait_st(input logic [2:0] s, input int lim);
    int k;
    k = 0;
    while (bus.state_dbg !== s && k < lim) begin
      tick();
      k++;
    end
    if (bus.state_dbg !== s) begin
      n_chk++;
      $display("FAIL wait_state: state %0d expected %0d within %0d cycles", bus.state_dbg, s, lim);
    end
  endtask
  always @(negedge clk) begin
    assert (!(bus.rst_io && !bus.rst_core) && !(bus.idc_rst && !bus.rst_io))
    else begin
      n_chk++;
      $display("FAIL order: idc_rst %b rst_io %b rst_core %b", bus.idc_rst, bus.rst_io, bus.rst_core);
    end
  end
  typedef struct {
    bit r;
    bit l;
    bit y;
    int n;
    logic [2:0] st;
    logic [2:0] rs;
    bit sr;
  } vec_t;
  function automatic vec_t v(bit r, bit l, bit y, int n, logic [2:0] st, logic [2:0] rs, bit sr);
    vec_t t;
    t.r = r; t.l = l; t.y = y; t.n = n; t.st = st; t.rs = rs; t.sr = sr;
    return t;
  endfunction
  vec_t tv[17];
  initial begin
    tv[0]  = v(1, 0, 0, 2, 0, 3'b111, 0);
    tv[1]  = v(0, 1, 0, 9, 0, 3'b111, 0);
    tv[2]  = v(0, 1, 0, 1, 1, 3'b111, 0);
    tv[3]  = v(0, 1, 0, 3, 1, 3'b111, 0);
    tv[4]  = v(0, 1, 0, 1, 2, 3'b011, 0);
    tv[5]  = v(0, 1, 0, 5, 2, 3'b011, 0);
    tv[6]  = v(0, 1, 1, 2, 2, 3'b011, 0);
    tv[7]  = v(0, 1, 1, 1, 3, 3'b001, 0);
    tv[8]  = v(0, 1, 1, 2, 3, 3'b001, 0);
    tv[9]  = v(0, 1, 1, 1, 4, 3'b000, 0);
    tv[10] = v(0, 1, 1, 1, 5, 3'b000, 1);
    tv[11] = v(0, 1, 1, 4, 5, 3'b000, 1);
    tv[12] = v(1, 0, 0, 2, 0, 3'b111, 0);
    tv[13] = v(0, 1, 0, 6, 0, 3'b111, 0);
    tv[14] = v(0, 0, 0, 1, 0, 3'b111, 0);
    tv[15] = v(0, 1, 0, 9, 0, 3'b111, 0);
    tv[16] = v(0, 1, 0, 1, 1, 3'b111, 0);
    for (int i = 0; i < 17; i++) begin
      rst = tv[i].r; lk = tv[i].l; rd = tv[i].y;
      ticks(tv[i].n);
      chk($sformatf("row%0d", i), 32'({bus.state_dbg, bus.idc_rst, bus.rst_io, bus.rst_core, bus.sys_ready}),
          32'({tv[i].st, tv[i].rs, tv[i].sr}));
    end
    chk("nominal_loss_cnt", 32'(bus.lock_loss_cnt), 32'd0);
    rst = 1; lk = 1; rd = 0;
    ticks(2);
    rst = 0;
    wait_st(2, 40);
    ticks(15);
    chk("timeout_before", 32'({bus.state_dbg, bus.timeout_flag}), 32'({3'd2, 1'b0}));
    tick();
    chk("timeout_hit", 32'({bus.state_dbg, bus.timeout_flag, bus.idc_rst}), 32'({3'd1, 2'b11}));
    ticks(3);
    chk("retry_pulse_hold", 32'({bus.state_dbg, bus.idc_rst}), 32'({3'd1, 1'b1}));
    tick();
    chk("retry_pulse_end", 32'({bus.state_dbg, bus.idc_rst}), 32'({3'd2, 1'b0}));
    rd = 1;
    wait_st(5, 20);
    chk("timeout_sticky", 32'({bus.sys_ready, bus.timeout_flag}), 32'b11);
    rd = 0;
    wait_st(2, 20);
    rst = 1;
    tick();
    chk("rst_wait_rdy", 32'({bus.state_dbg, bus.idc_rst, bus.rst_io, bus.rst_core, bus.timeout_flag}),
        32'({3'd0, 4'b1110}));
    rst = 0; rd = 0;
    wait_st(2, 40);
    ticks(16);
    chk("timeout_again", 32'(bus.timeout_flag), 32'd1);
    rd = 1;
    wait_st(3, 40);
    rst = 1;
    tick();
    chk("rst_rel_io", 32'({bus.state_dbg, bus.idc_rst, bus.rst_io, bus.rst_core, bus.timeout_flag}),
        32'({3'd0, 4'b1110}));
    rst = 0; lk = 1; rd = 1;
    wait_st(5, 60);
    for (int i = 0; i < 5; i++) begin
      lk = 0;
      ticks(2);
      chk("loss_latency", 32'(bus.state_dbg), 32'd5);
      tick();
      chk("loss_resets", 32'({bus.state_dbg, bus.idc_rst, bus.rst_io, bus.rst_core, bus.sys_ready}),
          32'({3'd0, 4'b1110}));
      ticks(17);
      lk = 1;
      wait_st(5, 60);
      if (i == 2) chk("loss_cnt3", 32'({bus.lock_loss_cnt, bus2.lock_loss_cnt}), 32'({8'd3, 2'd3}));
    end
    chk("loss_cnt5", 32'({bus.lock_loss_cnt, bus2.lock_loss_cnt}), 32'({8'd5, 2'd3}));
    rd = 0;
    ticks(2);
    chk("rdy_loss_latency", 32'(bus.state_dbg), 32'd5);
    tick();
    chk("rdy_loss", 32'({bus.state_dbg, bus.rst_io, bus.rst_core, bus.lock_loss_cnt, bus2.lock_loss_cnt}),
        32'({3'd1, 2'b11, 8'd5, 2'd3}));
    for (int s = 0; s < 150; s++) begin
      int n;
      rst = $urandom_range(0, 40) == 0;
      lk = $urandom_range(0, 7) != 0;
      rd = $urandom_range(0, 4) != 0;
      n = rst ? 1 : int'($urandom_range(1, 30));
      ticks(n);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
